// File: rtl/ltc_adc_8_parallel_reader.sv
// ltc_adc_8_parallel_reader
// Sequencer for eight parallel-output 12-bit ADCs that share one data bus,
// one conversion-start line and one read strobe. Each ADC has its own
// active-low chip select and BUSY line. A start pulse fires a simultaneous
// conversion, waits for the selected converters, then reads the selected
// channels one at a time, lowest index first.
//
// Optional feature macro: LTC_ADC_TIMEOUT_EN bounds the BUSY wait to
// TIMEOUT_CYCLES cycles and reports an abort on o_timeout_err. When the
// macro is not defined the wait is unbounded and o_timeout_err is tied 0.
//
// Ports:
//   i_clk, i_reset      clock; synchronous active-high reset
//   i_start             one-cycle pulse, accepted only when idle
//   i_chan_mask[7:0]    channels to read, sampled with an accepted start
//   i_adc_data[11:0]    shared ADC data bus
//   i_adc_busy[7:0]     per-ADC BUSY, active-high, already synchronized
//   o_convst            shared conversion start, active-high
//   o_cs_n[7:0]         per-ADC chip select, active-low
//   o_rd_n              shared read strobe, active-low
//   o_sample_data/index result and its channel, held between valids
//   o_sample_valid      one-cycle qualifier for sample_data/index
//   o_done              one-cycle end-of-sequence pulse
//   o_busy              sequence in progress (low in the done cycle)
//   o_timeout_err       sticky abort flag, cleared by next accepted start
module ltc_adc_8_parallel_reader #(
  parameter int unsigned CONVST_CYCLES  = 2,
  parameter int unsigned BLANK_CYCLES   = 2,
  parameter int unsigned RD_CYCLES      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [7:0]  i_chan_mask,
  input  logic [11:0] i_adc_data,
  input  logic [7:0]  i_adc_busy,
  output logic        o_convst,
  output logic [7:0]  o_cs_n,
  output logic        o_rd_n,
  output logic [11:0] o_sample_data,
  output logic [2:0]  o_sample_index,
  output logic        o_sample_valid,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_BLANK, S_WAIT, S_READ, S_GAP, S_DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_mask;
  logic [7:0]  r_cnt;
  logic [2:0]  r_chan;
  logic        r_convst;
  logic [7:0]  r_cs_n;
  logic        r_rd_n;
  logic [11:0] r_sample_data;
  logic [2:0]  r_sample_index;
  logic        r_sample_valid;
  logic        r_done;
  logic        r_busy;

  // Lowest set bit of a channel mask; callers only use it on nonzero masks.
  function automatic logic [2:0] f_lowest(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Chip-select pattern with only channel idx driven low.
  function automatic logic [7:0] f_cs_n(input logic [2:0] idx);
    return ~(8'd1 << idx);
  endfunction

  logic [7:0] w_mask_rest;
  logic       w_busy_clear;

  assign w_mask_rest  = r_mask & ~(8'd1 << r_chan);
  // Only the channels being read gate the wait; other BUSY lines are ignored.
  assign w_busy_clear = ((i_adc_busy & r_mask) == 8'd0);

`ifdef LTC_ADC_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_timeout_err;
  assign o_timeout_err = r_timeout_err;
`else
  assign o_timeout_err = 1'b0;
`endif

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_mask         <= 8'd0;
      r_cnt          <= 8'd0;
      r_chan         <= 3'd0;
      r_convst       <= 1'b0;
      r_cs_n         <= 8'hFF;
      r_rd_n         <= 1'b1;
      r_sample_data  <= 12'd0;
      r_sample_index <= 3'd0;
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
`ifdef LTC_ADC_TIMEOUT_EN
      r_wait_cnt     <= 16'd0;
      r_timeout_err  <= 1'b0;
`endif
    end else begin
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_mask <= i_chan_mask;
            r_cnt  <= 8'd0;
`ifdef LTC_ADC_TIMEOUT_EN
            r_timeout_err <= 1'b0;
`endif
            if (i_chan_mask != 8'd0) begin
              r_state  <= S_CONV;
              r_convst <= 1'b1;
              r_busy   <= 1'b1;
            end else begin
              // Nothing to read: finish without touching the converters.
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_CONV: begin
          if (r_cnt == 8'(CONVST_CYCLES - 1)) begin
            r_convst <= 1'b0;
            r_cnt    <= 8'd0;
`ifdef LTC_ADC_TIMEOUT_EN
            r_wait_cnt <= 16'd0;
`endif
            r_state  <= (BLANK_CYCLES == 0) ? S_WAIT : S_BLANK;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_BLANK: begin
          // BUSY may not yet be asserted right after convst; do not look at it.
          if (r_cnt == 8'(BLANK_CYCLES - 1)) begin
            r_cnt   <= 8'd0;
            r_state <= S_WAIT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WAIT: begin
          if (w_busy_clear) begin
            r_chan  <= f_lowest(r_mask);
            r_cs_n  <= f_cs_n(f_lowest(r_mask));
            r_rd_n  <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= S_READ;
`ifdef LTC_ADC_TIMEOUT_EN
          end else if (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            r_state       <= S_DONE;
            r_done        <= 1'b1;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
`endif
          end
        end
        S_READ: begin
          // Bus is sampled on the final strobe cycle, then released.
          if (r_cnt == 8'(RD_CYCLES - 1)) begin
            r_sample_data  <= i_adc_data;
            r_sample_index <= r_chan;
            r_sample_valid <= 1'b1;
            r_cs_n         <= 8'hFF;
            r_rd_n         <= 1'b1;
            r_state        <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_GAP: begin
          r_mask <= w_mask_rest;
          if (w_mask_rest != 8'd0) begin
            r_chan  <= f_lowest(w_mask_rest);
            r_cs_n  <= f_cs_n(f_lowest(w_mask_rest));
            r_rd_n  <= 1'b0;
            r_cnt   <= 8'd0;
            r_state <= S_READ;
          end else begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        S_DONE: begin
          // A start seen here is dropped; acceptance resumes next cycle.
          r_state <= S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_convst <= 1'b0;
          r_cs_n   <= 8'hFF;
          r_rd_n   <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign o_convst       = r_convst;
  assign o_cs_n         = r_cs_n;
  assign o_rd_n         = r_rd_n;
  assign o_sample_data  = r_sample_data;
  assign o_sample_index = r_sample_index;
  assign o_sample_valid = r_sample_valid;
  assign o_done         = r_done;
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_ltc_adc_8_parallel_reader.sv
// Self-checking bench for ltc_adc_8_parallel_reader (default parameters).
// Table of sequences {mask, BUSY pattern, optional second start, data base,
// expected done cycle, expected timeout flag}; cycle 1 is the cycle after the
// edge that accepts start. The ADC model drives data_base + channel onto the
// bus whenever exactly that channel's chip select is low.
module tb_ltc_adc_8_parallel_reader;

  localparam int C  = 2;
  localparam int B  = 2;
  localparam int RD = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  chan_mask;
  logic [11:0] adc_data;
  logic [7:0]  adc_busy;
  logic        convst;
  logic [7:0]  cs_n;
  logic        rd_n;
  logic [11:0] sample_data;
  logic [2:0]  sample_index;
  logic        sample_valid;
  logic        done;
  logic        busy;
  logic        timeout_err;
  logic [11:0] data_base;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ltc_adc_8_parallel_reader dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_chan_mask    (chan_mask),
    .i_adc_data     (adc_data),
    .i_adc_busy     (adc_busy),
    .o_convst       (convst),
    .o_cs_n         (cs_n),
    .o_rd_n         (rd_n),
    .o_sample_data  (sample_data),
    .o_sample_index (sample_index),
    .o_sample_valid (sample_valid),
    .o_done         (done),
    .o_busy         (busy),
    .o_timeout_err  (timeout_err)
  );

  // ADC bus model
  always_comb begin
    adc_data = 12'h000;
    for (int i = 0; i < 8; i++) begin
      if (!cs_n[i]) adc_data = data_base + 12'(i);
    end
  end

  typedef struct {
    logic [7:0]  mask;
    logic [7:0]  bbits;
    int          blo;
    int          bhi;
    int          rcyc;
    logic [7:0]  rmask;
    logic [11:0] base;
    int          exp_done;
    logic        exp_to;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int cyc, done_cyc, nval, conv_cnt, rd_low, proto_err, busy_err, en;
    logic [2:0]  gi [8];
    logic [11:0] gd [8];
    logic [2:0]  ei [8];
    logic        to_at_done;
    string       tag;
    tag = $sformatf("v%0d", id);
    en = 0;
    for (int i = 0; i < 8; i++) begin
      gi[i] = 3'd0; gd[i] = 12'd0; ei[i] = 3'd0;
    end
    if (!v.exp_to) begin
      for (int i = 0; i < 8; i++) begin
        if (v.mask[i]) begin ei[en] = 3'(i); en++; end
      end
    end
    data_base = v.base;
    done_cyc = -1; nval = 0; conv_cnt = 0; rd_low = 0;
    proto_err = 0; busy_err = 0; to_at_done = 1'b0;
    @(negedge clk);
    start = 1'b1; chan_mask = v.mask;
    @(posedge clk); #1;
    chan_mask = ~v.mask;  // must have no effect after acceptance
    cyc = 1;
    while (cyc <= 600 && done_cyc < 0) begin
      adc_busy = (cyc >= v.blo && cyc <= v.bhi) ? v.bbits : 8'h00;
      if (cyc == v.rcyc) begin start = 1'b1; chan_mask = v.rmask; end
      else start = 1'b0;
      @(negedge clk);
      if (convst) conv_cnt++;
      if (!rd_n) rd_low++;
      if ((cs_n != 8'hFF) != !rd_n) proto_err++;
      if ($countones(~cs_n) > 1) proto_err++;
      if (sample_valid) begin
        if (nval < 8) begin gi[nval] = sample_index; gd[nval] = sample_data; end
        nval++;
      end
      if (done) begin
        done_cyc = cyc; to_at_done = timeout_err;
        if (busy) busy_err++;
      end else if (busy != (v.mask != 8'h00)) busy_err++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; adc_busy = 8'h00;
    @(negedge clk);
    check({tag, "_idle_after_done"}, {31'd0, convst | busy}, 0);
    check({tag, "_done_cycle"}, done_cyc, v.exp_done);
    check({tag, "_nvalid"}, nval, en);
    for (int k = 0; k < 8; k++) begin
      if (k < en && k < nval) begin
        check($sformatf("%s_idx%0d", tag, k), int'(gi[k]), int'(ei[k]));
        check($sformatf("%s_data%0d", tag, k), int'(gd[k]), int'(v.base + 12'(ei[k])));
      end
    end
    check({tag, "_convst_cycles"}, conv_cnt, (v.mask != 8'h00) ? C : 0);
    check({tag, "_rd_low_cycles"}, rd_low, en * RD);
    check({tag, "_protocol"}, proto_err, 0);
    check({tag, "_busy_flag"}, busy_err, 0);
    check({tag, "_timeout_err"}, int'(to_at_done), int'(v.exp_to));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    vec_t vr;
    int   nv;
    int   ev;

    vecs[0] = '{8'h01, 8'h01, 3, 8,   0,  8'h00, 12'hABC, 14,  1'b0};
    vecs[1] = '{8'hA5, 8'h00, 0, 0,   0,  8'h00, 12'h100, 22,  1'b0};
    vecs[2] = '{8'h00, 8'h00, 0, 0,   0,  8'h00, 12'h000, 1,   1'b0};
    vecs[3] = '{8'h80, 8'h80, 1, 12,  0,  8'h00, 12'h200, 18,  1'b0};
    vecs[4] = '{8'h0F, 8'hF0, 1, 300, 0,  8'h00, 12'h300, 22,  1'b0};
    vecs[5] = '{8'hFF, 8'h00, 0, 0,   38, 8'h01, 12'h7F0, 38,  1'b0};
    vecs[6] = '{8'h02, 8'h02, 1, 4,   0,  8'h00, 12'h0A0, 10,  1'b0};
    vecs[7] = '{8'h01, 8'h01, 1, 10,  7,  8'hF0, 12'h555, 16,  1'b0};
    vecs[8] = '{8'h08, 8'h08, 1, 999, 0,  8'h00, 12'h400, 260, 1'b1};
    vecs[9] = '{8'h08, 8'h00, 0, 0,   0,  8'h00, 12'h410, 10,  1'b0};
`ifdef LTC_ADC_TIMEOUT_EN
    nv = 10;
`else
    nv = 8;
`endif

    reset = 1'b1; start = 1'b0; chan_mask = 8'h00; adc_busy = 8'h00;
    data_base = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_convst", int'(convst), 0);
    check("rst_cs_n", int'(cs_n), 'hFF);
    check("rst_rd_n", int'(rd_n), 1);
    check("rst_sample", int'({sample_data, sample_index, sample_valid}), 0);
    check("rst_done_busy", int'({done, busy, timeout_err}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset while channel 2 is being read.
    data_base = 12'h020;
    @(negedge clk);
    start = 1'b1; chan_mask = 8'h04;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_pre_cs_n", int'(cs_n), 'hFB);
    check("midrst_pre_rd_n", int'(rd_n), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", int'(cs_n), 'hFF);
    check("midrst_rd_n", int'(rd_n), 1);
    check("midrst_busy_done_valid", int'({busy, done, sample_valid}), 0);
    ev = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || sample_valid || convst || busy) ev++;
    end
    check("midrst_quiet", ev, 0);
    vr = '{8'h04, 8'h00, 0, 0, 0, 8'h00, 12'h040, 10, 1'b0};
    run_vec(vr, 99);

    for (int i = 0; i < nv; i++) begin
      run_vec(vecs[i], i);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ltc_adc_8_parallel_reader.md
# ltc_adc_8_parallel_reader

Readback counterpart to the 8-DAC parallel write interface: controls eight parallel-output 12-bit ADCs that share one data bus, one conversion-start line and one read strobe, each with its own active-low chip select and BUSY output. On a start pulse it launches a simultaneous conversion on all ADCs and waits for the selected converters to finish. It then reads the selected channels one at a time, lowest index first, and emits each result as a one-cycle valid-qualified sample. It sits between the ADC pins (board I/O, inputs pre-synchronized) and the acquisition logic.

## Interface
- CONVST_CYCLES, 2, convst high width in clk cycles (1–255)
- BLANK_CYCLES, 2, cycles after convst during which adc_busy is ignored (0–255)
- RD_CYCLES, 3, rd_n/cs_n low width per channel read (1–255)
- TIMEOUT_CYCLES, 255, max WAIT cycles before abort (used only with LTC_ADC_TIMEOUT_EN; 1–65535)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins conversion+readout
- chan_mask  in  8  channels to read; sampled with start
- adc_data  in  12  shared ADC data bus
- adc_busy  in  8  per-ADC BUSY, active-high, pre-synchronized
- convst  out  1  shared conversion start, active-high
- cs_n  out  8  per-ADC chip select, active-low
- rd_n  out  1  shared read strobe, active-low
- sample_data  out  12  captured result
- sample_index  out  3  channel of sample_data
- sample_valid  out  1  one-cycle qualifier
- done  out  1  one-cycle pulse at end of sequence
- busy  out  1  high from cycle after accepted start until the done cycle
- timeout_err  out  1  sticky abort flag, cleared by next accepted start

## Operation
- Reset values: convst=0, cs_n=8'hFF, rd_n=1, sample_data=0, sample_index=0, sample_valid=0, done=0, busy=0, timeout_err=0, state IDLE, mask register 0.
- States: IDLE, CONV, BLANK, WAIT, READ, GAP, DONE.
- IDLE: start=1 latches chan_mask, clears timeout_err. Mask nonzero → CONV (convst=1, busy=1). Mask zero → DONE directly, no convst.
- CONV: convst=1 for CONVST_CYCLES cycles → BLANK (BLANK_CYCLES=0 → straight to WAIT).
- BLANK: convst=0 for BLANK_CYCLES cycles, adc_busy ignored → WAIT.
- WAIT: when (adc_busy & mask)==0, select the lowest set mask bit → READ next cycle. Unselected channels' BUSY ignored.
- READ: cs_n[i]=0 (only bit i), rd_n=0 for RD_CYCLES cycles; adc_data captured on the last of those cycles.
- GAP: one cycle, rd_n=1, cs_n=8'hFF, sample_valid=1 with sample_data/sample_index; bit i cleared from the mask register. Remaining bits → READ for next lowest index; none → DONE.
- DONE: done=1, busy=0 for one cycle → IDLE.
- start while not IDLE is ignored; chan_mask changes after acceptance have no effect.
- rd_n and cs_n never low outside READ; at most one cs_n bit low at any time.
- sample_data/sample_index hold their last values between valids.
- reset mid-operation: all outputs to reset values at that edge; no done, no sample_valid.

## Timing
- Accepted start at edge 0: convst high cycles 1..C (C=CONVST_CYCLES), blank cycles C+1..C+B.
- WAIT entered at cycle C+B+1; with BUSY already low, first READ begins next cycle.
- Per channel: RD_CYCLES + 1 cycles (READ + GAP). N channels, zero BUSY wait: done at cycle C+B+1 + N·(RD_CYCLES+1) + 1.
- Mask zero: done at cycle 1, busy never asserted.
- Back-to-back: start in the DONE cycle is ignored; earliest acceptance is the cycle after DONE.

## Configuration
- LTC_ADC_TIMEOUT_EN defined: WAIT counts cycles; if selected BUSY still high after TIMEOUT_CYCLES cycles in WAIT, go to DONE with timeout_err=1 (same cycle as done), no reads, no sample_valid.
- Not defined: WAIT lasts indefinitely; counter logic absent; timeout_err tied 0.

## Test plan
- Default parameters, chan_mask=8'h01, adc_busy[0] high cycles 3–8, adc_data=12'hABC → cs_n=8'hFE with rd_n low 3 cycles, one sample_valid with index 0, data 12'hABC, then done.
- chan_mask=8'hA5, BUSY low, adc_data = 12'h100+index during each read → four valids, indices 0,2,5,7 in order, data 12'h100/102/105/107, done at cycle 22.
- chan_mask=8'h00 → done at cycle 1, convst/cs_n/rd_n never asserted, busy stays 0.
- LTC_ADC_TIMEOUT_EN, adc_busy[3] stuck high, chan_mask=8'h08 → done and timeout_err=1 after 255 WAIT cycles, no sample_valid; next start clears timeout_err.
- Reset asserted during READ of channel 2 → next cycle cs_n=8'hFF, rd_n=1, busy=0, no done; fresh start then completes normally.
- start pulsed again during WAIT with a different mask → ignored; original mask's samples only.
